// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between multi_cycle_ctrl and the multi-cycle datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface multi_cycle_ctrl_if;
  logic [6:0]  OPCODE;
  logic        BR_TAKEN;
  logic        MEM_READY;
  logic        PC_WRITE;
  logic        IR_WRITE;
  logic        REG_WRITE;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        IORD;
  logic        PC_SRC;
  logic [1:0]  ALU_SRC_A;
  logic [2:0]  ALU_SRC_B;
  logic [1:0]  ALU_OP;
  logic [1:0]  WB_SEL;
  logic [2:0]  STATE;
  logic        HALTED;
  logic        INSTR_DONE;
  logic [31:0] RETIRED;

  modport master (
    input  OPCODE, BR_TAKEN, MEM_READY,
    output PC_WRITE, IR_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, IORD, PC_SRC,
           ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, STATE, HALTED, INSTR_DONE, RETIRED
  );

  modport slave (
    output OPCODE, BR_TAKEN, MEM_READY,
    input  PC_WRITE, IR_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, IORD, PC_SRC,
           ALU_SRC_A, ALU_SRC_B, ALU_OP, WB_SEL, STATE, HALTED, INSTR_DONE, RETIRED
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I CPU: IF/ID/EX/MEM/WB sequencing,
// memory wait states, halt on SYSTEM/illegal opcodes, retired-instruction count.
module multi_cycle_ctrl (
  input logic                  CLK,
  input logic                  RESET,
  multi_cycle_ctrl_if.master   bus
);
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_CMP  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [6:0]  op_q;
  logic [31:0] retired;
  logic        retire;
  logic        known_op;

  // ID decides from the live OPCODE because op_q is only loaded on the ID edge.
  always_comb begin
    case (bus.OPCODE)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known_op = 1'b1;
      default:                           known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IF:   if (bus.MEM_READY) state_next = S_ID;
      S_ID:   state_next = known_op ? S_EX : S_HALT;
      S_EX: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_next = S_MEM;
          OP_BRANCH: begin
            state_next = S_IF;
            retire     = 1'b1;
          end
          default:           state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.MEM_READY) begin
          if (op_q == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            state_next = S_IF;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        state_next = S_IF;
        retire     = 1'b1;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IF;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == S_ID) op_q <= bus.OPCODE;
      if (retire) retired <= retired + 32'd1;
    end
  end

  assign bus.STATE   = state;
  assign bus.RETIRED = retired;

  always_comb begin
    bus.PC_WRITE   = 1'b0;
    bus.IR_WRITE   = 1'b0;
    bus.REG_WRITE  = 1'b0;
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b0;
    bus.IORD       = 1'b0;
    bus.PC_SRC     = 1'b0;
    bus.ALU_SRC_A  = 2'b00;
    bus.ALU_SRC_B  = 3'b000;
    bus.ALU_OP     = ALU_ADD;
    bus.WB_SEL     = 2'b00;
    bus.HALTED     = 1'b0;
    bus.INSTR_DONE = 1'b0;
    if (!RESET) begin
      bus.INSTR_DONE = retire;
      case (state)
        S_IF: begin
          bus.MEM_READ  = 1'b1;
          bus.ALU_SRC_B = 3'b001;
          bus.IR_WRITE  = bus.MEM_READY;
          bus.PC_WRITE  = bus.MEM_READY;
        end
        S_ID: begin
          bus.ALU_SRC_A = 2'b10;
          bus.ALU_SRC_B = 3'b010;
        end
        S_EX: begin
          case (op_q)
            OP_R: begin
              bus.ALU_SRC_A = 2'b01;
              bus.ALU_OP    = ALU_FUNC;
            end
            OP_I: begin
              bus.ALU_SRC_A = 2'b01;
              bus.ALU_SRC_B = 3'b010;
              bus.ALU_OP    = ALU_FUNC;
            end
            OP_LOAD, OP_STORE: begin
              bus.ALU_SRC_A = 2'b01;
              bus.ALU_SRC_B = 3'b010;
            end
            OP_BRANCH: begin
              bus.ALU_SRC_A = 2'b01;
              bus.ALU_OP    = ALU_CMP;
              bus.PC_SRC    = 1'b1;
              bus.PC_WRITE  = bus.BR_TAKEN;
            end
            OP_JAL: begin
              bus.PC_SRC   = 1'b1;
              bus.PC_WRITE = 1'b1;
            end
            OP_JALR: begin
              bus.ALU_SRC_A = 2'b01;
              bus.ALU_SRC_B = 3'b010;
              bus.PC_WRITE  = 1'b1;
            end
            OP_LUI: begin
              bus.ALU_SRC_B = 3'b010;
              bus.ALU_OP    = ALU_PASS;
            end
            OP_AUIPC: begin
              bus.ALU_SRC_A = 2'b10;
              bus.ALU_SRC_B = 3'b010;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.IORD      = 1'b1;
          bus.MEM_READ  = (op_q == OP_LOAD);
          bus.MEM_WRITE = (op_q == OP_STORE);
        end
        S_WB: begin
          bus.REG_WRITE = 1'b1;
          if (op_q == OP_LOAD)                         bus.WB_SEL = 2'b01;
          else if (op_q == OP_JAL || op_q == OP_JALR)  bus.WB_SEL = 2'b10;
        end
        S_HALT: bus.HALTED = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a phase-sequence reference model.
module tb_multi_cycle_ctrl;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic CLK;
  logic RESET;
  multi_cycle_ctrl_if bus ();

  int checks;
  int passes;
  int exp_retired;

  multi_cycle_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_end(input string name);
    checks++;
    if ({bus.STATE, bus.RETIRED} !== {3'd0, 32'(exp_retired)})
      $display("FAIL %s_end: state=%0d retired=%0d, want state=0 retired=%0d",
               name, bus.STATE, bus.RETIRED, exp_retired);
    else passes++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.MEM_READY = 1'b1;
    bus.BR_TAKEN = 1'b0;
    bus.OPCODE = OP_R;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({bus.PC_WRITE, bus.IR_WRITE, bus.REG_WRITE, bus.MEM_READ, bus.MEM_WRITE} !== 5'b0)
        $display("FAIL reset_enables: cycle %0d got %b want 00000", c,
                 {bus.PC_WRITE, bus.IR_WRITE, bus.REG_WRITE, bus.MEM_READ, bus.MEM_WRITE});
      else passes++;
      tick();
    end
    RESET = 1'b0;
    exp_retired = 0;
    checks++;
    if ({bus.STATE, bus.RETIRED} !== {3'd0, 32'd0})
      $display("FAIL reset_state: state=%0d retired=%0d want 0 0", bus.STATE, bus.RETIRED);
    else passes++;
    #1;
    checks++;
    if ({bus.MEM_READ, bus.HALTED, bus.INSTR_DONE} !== 3'b100)
      $display("FAIL reset_first_fetch: mem_read/halted/done=%b want 100",
               {bus.MEM_READ, bus.HALTED, bus.INSTR_DONE});
    else passes++;
  endtask

  task automatic test_alu_seq();
    int st[4];
    st = '{0, 1, 2, 4};
    bus.OPCODE = OP_R;
    bus.MEM_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({bus.STATE, bus.REG_WRITE, bus.INSTR_DONE, bus.WB_SEL} !== {3'(st[k]), k == 3, k == 3, 2'b00})
        $display("FAIL alu_seq: cycle %0d state/rw/done/wbsel got %b want %b", k,
                 {bus.STATE, bus.REG_WRITE, bus.INSTR_DONE, bus.WB_SEL},
                 {3'(st[k]), k == 3, k == 3, 2'b00});
      else passes++;
      tick();
    end
    exp_retired++;
    check_end("alu_seq");
  endtask

  task automatic test_load_wait();
    int st[7];
    bit rdy[7];
    bit mr[7];
    bit io[7];
    st  = '{0, 1, 2, 3, 3, 3, 4};
    rdy = '{1, 0, 0, 0, 0, 1, 0};
    mr  = '{1, 0, 0, 1, 1, 1, 0};
    io  = '{0, 0, 0, 1, 1, 1, 0};
    bus.OPCODE = OP_LOAD;
    for (int k = 0; k < 7; k++) begin
      bus.MEM_READY = rdy[k];
      #1;
      checks++;
      if ({bus.STATE, bus.MEM_READ, bus.IORD, bus.INSTR_DONE, bus.WB_SEL} !==
          {3'(st[k]), mr[k], io[k], k == 6, (k == 6) ? 2'b01 : 2'b00})
        $display("FAIL load_wait: cycle %0d state/mr/iord/done/wbsel got %b want %b", k,
                 {bus.STATE, bus.MEM_READ, bus.IORD, bus.INSTR_DONE, bus.WB_SEL},
                 {3'(st[k]), mr[k], io[k], k == 6, (k == 6) ? 2'b01 : 2'b00});
      else passes++;
      tick();
    end
    exp_retired++;
    check_end("load_wait");
  endtask

  task automatic test_branches();
    bit taken;
    for (int t = 0; t < 2; t++) begin
      taken = (t == 0);
      bus.OPCODE = OP_BRANCH;
      bus.MEM_READY = 1'b1;
      bus.BR_TAKEN = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (k == 2) bus.BR_TAKEN = taken;
        #1;
        if (k == 1) begin
          checks++;
          if ({bus.STATE, bus.PC_WRITE} !== {3'd1, 1'b0})
            $display("FAIL branch_id: state/pcw got %b want 0010", {bus.STATE, bus.PC_WRITE});
          else passes++;
        end
        if (k == 2) begin
          checks++;
          if ({bus.STATE, bus.PC_WRITE, bus.PC_SRC, bus.INSTR_DONE, bus.ALU_OP} !==
              {3'd2, taken, 1'b1, 1'b1, 2'b01})
            $display("FAIL branch_ex: taken=%0d state/pcw/pcsrc/done/aluop got %b want %b", taken,
                     {bus.STATE, bus.PC_WRITE, bus.PC_SRC, bus.INSTR_DONE, bus.ALU_OP},
                     {3'd2, taken, 1'b1, 1'b1, 2'b01});
          else passes++;
        end
        tick();
      end
      bus.BR_TAKEN = 1'b0;
      exp_retired++;
      check_end("branch");
    end
  endtask

  task automatic test_jal_jalr();
    bit is_jalr;
    for (int j = 0; j < 2; j++) begin
      is_jalr = (j == 1);
      bus.OPCODE = is_jalr ? OP_JALR : OP_JAL;
      bus.MEM_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
        #1;
        if (k == 2) begin
          checks++;
          if ({bus.STATE, bus.PC_WRITE, bus.PC_SRC, bus.ALU_SRC_A, bus.ALU_SRC_B} !==
              {3'd2, 1'b1, !is_jalr, is_jalr ? 2'b01 : 2'b00, is_jalr ? 3'b010 : 3'b000})
            $display("FAIL jump_ex: jalr=%0d state/pcw/pcsrc/srca/srcb got %b want %b", is_jalr,
                     {bus.STATE, bus.PC_WRITE, bus.PC_SRC, bus.ALU_SRC_A, bus.ALU_SRC_B},
                     {3'd2, 1'b1, !is_jalr, is_jalr ? 2'b01 : 2'b00, is_jalr ? 3'b010 : 3'b000});
          else passes++;
        end
        if (k == 3) begin
          checks++;
          if ({bus.STATE, bus.REG_WRITE, bus.WB_SEL, bus.INSTR_DONE} !== {3'd4, 1'b1, 2'b10, 1'b1})
            $display("FAIL jump_wb: jalr=%0d state/rw/wbsel/done got %b want 1001101", is_jalr,
                     {bus.STATE, bus.REG_WRITE, bus.WB_SEL, bus.INSTR_DONE});
          else passes++;
        end
        tick();
      end
      exp_retired++;
      check_end("jump");
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[9];
    logic [6:0] op;
    int iw, mw, ph;
    bit rdy, brv, ld, st, br, jmp;
    int ph_q[$];
    bit rdy_q[$];
    logic [12:0] got, expv;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int n = 0; n < 40; n++) begin
      op  = ops[$urandom_range(0, 8)];
      iw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      ld  = (op == OP_LOAD);
      st  = (op == OP_STORE);
      br  = (op == OP_BRANCH);
      jmp = (op == OP_JAL) || (op == OP_JALR);
      ph_q.delete();
      rdy_q.delete();
      for (int i = 0; i <= iw; i++) begin ph_q.push_back(0); rdy_q.push_back(i == iw); end
      ph_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
      ph_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (ld || st)
        for (int i = 0; i <= mw; i++) begin ph_q.push_back(3); rdy_q.push_back(i == mw); end
      if (!(br || st)) begin ph_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1))); end
      bus.OPCODE = op;
      for (int k = 0; k < ph_q.size(); k++) begin
        ph  = ph_q[k];
        rdy = rdy_q[k];
        brv = 1'($urandom_range(0, 1));
        bus.MEM_READY = rdy;
        bus.BR_TAKEN = brv;
        expv = {3'(ph),
                k == ph_q.size() - 1,
                (ph == 0) ? rdy : ((ph == 2) ? (br ? brv : jmp) : 1'b0),
                (ph == 0) && rdy,
                ph == 4,
                (ph == 0) || (ph == 3 && ld),
                ph == 3 && st,
                ph == 3,
                1'b0,
                (ph == 4) ? (ld ? 2'b01 : (jmp ? 2'b10 : 2'b00)) : 2'b00};
        #1;
        got = {bus.STATE, bus.INSTR_DONE, bus.PC_WRITE, bus.IR_WRITE, bus.REG_WRITE,
               bus.MEM_READ, bus.MEM_WRITE, bus.IORD, bus.HALTED, bus.WB_SEL};
        checks++;
        if (got !== expv)
          $display("FAIL random: instr %0d op %b cycle %0d got %b want %b", n, op, k, got, expv);
        else passes++;
        tick();
      end
      exp_retired++;
      check_end("random");
    end
    bus.BR_TAKEN = 1'b0;
  endtask

  task automatic test_halt_abort();
    bus.OPCODE = OP_SYSTEM;
    bus.MEM_READY = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.STATE !== 3'd1) $display("FAIL halt_id: state=%0d want 1", bus.STATE);
    else passes++;
    tick();
    for (int c = 0; c < 20; c++) begin
      bus.MEM_READY = 1'($urandom_range(0, 1));
      bus.BR_TAKEN = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({bus.STATE, bus.HALTED, bus.PC_WRITE, bus.IR_WRITE, bus.REG_WRITE, bus.MEM_READ,
           bus.MEM_WRITE, bus.INSTR_DONE, bus.RETIRED} !== {3'd5, 1'b1, 6'b0, 32'(exp_retired)})
        $display("FAIL halt_sticky: cycle %0d state=%0d halted=%0d retired=%0d want 5 1 %0d",
                 c, bus.STATE, bus.HALTED, bus.RETIRED, exp_retired);
      else passes++;
      tick();
    end
    bus.BR_TAKEN = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_retired = 0;
    check_end("halt_reset");
    bus.OPCODE = OP_STORE;
    bus.MEM_READY = 1'b1;
    tick();
    tick();
    tick();
    bus.MEM_READY = 1'b0;
    #1;
    checks++;
    if ({bus.STATE, bus.MEM_WRITE, bus.IORD} !== {3'd3, 1'b1, 1'b1})
      $display("FAIL store_mem: state/mw/iord got %b want 01111", {bus.STATE, bus.MEM_WRITE, bus.IORD});
    else passes++;
    tick();
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.STATE, bus.MEM_WRITE, bus.INSTR_DONE} !== {3'd3, 1'b0, 1'b0})
      $display("FAIL store_abort: state/mw/done got %b want 01100", {bus.STATE, bus.MEM_WRITE, bus.INSTR_DONE});
    else passes++;
    tick();
    RESET = 1'b0;
    check_end("store_abort");
  endtask

  initial begin
    checks = 0;
    passes = 0;
    exp_retired = 0;
    test_reset();
    test_alu_seq();
    test_load_wait();
    test_branches();
    test_jal_jalr();
    test_random();
    test_halt_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
